pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned word into a registered fetch/decode output with a valid/ready handshake.
- Handles branch/jump redirects and detects misaligned or out-of-range fetches, halting fetch on a fault until redirected.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
ROM_SIZE, 8, ROM depth in 32-bit words; addresses with (pc>>2) >= ROM_SIZE are out of range
NOP_INSTR, 32'h0000_0013, word placed on if_instr when no valid instruction exists (reset, fault)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_address_current  output  32  byte address to ROM; combinational copy of pc_q
current_instruction  input  32  ROM read data for cmd_address_current (same cycle)
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  redirect target byte address
if_ready  input  1  downstream accepts the output register this cycle
if_valid  output  1  output register holds a fetched entry
if_instr  output  32  fetched instruction
if_pc  output  32  byte address of if_instr
if_fault  output  1  entry is a fault marker (misaligned or out of range)

Behaviour:
- Reset (async, immediate on rst=1):
  - pc_q=RESET_PC, state=RUN, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_fault=0.
- States: RUN (fetching), FAULT (fetch frozen).
- Definitions:
  - fire = if_valid & if_ready.
  - slot_free = !if_valid | if_ready.
  - load = (state==RUN) & slot_free & !redirect_valid.
- Fault check on pc_q: bad = (pc_q[1:0]!=0) | ((pc_q>>2) >= ROM_SIZE).
- Priority each edge (highest first):
  1. redirect_valid: pc_q<=redirect_pc, if_valid<=0, if_fault<=0, state<=RUN. Any entry is dropped, whether or not it was consumed this cycle. No capture this cycle.
  2. load & !bad: if_instr<=current_instruction, if_pc<=pc_q, if_fault<=0, if_valid<=1, pc_q<=pc_q+4 (32-bit wrap, no carry out).
  3. load & bad: if_instr<=NOP_INSTR, if_pc<=pc_q, if_fault<=1, if_valid<=1, pc_q unchanged, state<=FAULT.
  4. Otherwise: if fire, if_valid<=0. All other state holds.
- Latency: instruction at pc_q appears on if_* one edge after pc_q is presented. Throughput is 1 instruction per clock with if_ready held high.
- Backpressure: if_valid=1 & if_ready=0 holds if_instr/if_pc/if_fault and pc_q stable, so cmd_address_current is constant.
- FAULT state: the fault entry is held until consumed. After that, if_valid=0 and no further loads occur. Only redirect_valid or rst leaves FAULT.
- A misaligned redirect_pc is accepted into pc_q; the fault is raised on the following load.
- Redirect in the same cycle as fire: downstream consumption stands; the next edge still loads redirect_pc and clears if_valid.
- First fetch after reset release: the first rising edge with rst=0 captures ROM[RESET_PC>>2].
- if_instr is NOP_INSTR whenever if_fault=1. It is don't-care-stable (last value) when if_valid=0.

Test Plan:
- Reset, RESET_PC=0, ROM[0..2]=0x00500093,0x00A00113,0x002081B3, if_ready=1:
  - edges 1/2/3 give if_pc=0/4/8 with those words and if_valid=1.
  - cmd_address_current=4/8/12 after each edge.
- Backpressure: after first entry, drop if_ready for 3 cycles:
  - if_pc=0, if_instr=0x00500093 held.
  - cmd_address_current stays 4.
  - on raise, if_pc=4 on the next edge.
- Redirect to 0x10 while if_valid=1, if_ready=0:
  - next edge if_valid=0 and cmd_address_current=0x10.
  - following edge if_pc=0x10 with if_instr=ROM[4].
- Misaligned redirect to 0x6:
  - next edge if_valid=0.
  - then if_valid=1, if_fault=1, if_pc=0x6, if_instr=0x00000013.
  - after consumption if_valid stays 0 for 5+ cycles.
  - redirect to 0x0 resumes with if_pc=0.
- Out of range, ROM_SIZE=8, sequential run from 0:
  - if_pc 0x00..0x1C are normal.
  - the entry at 0x20 has if_fault=1.
  - cmd_address_current then frozen at 0x20.
- Async reset mid-run: assert rst between edges at pc_q=0x0C:
  - outputs go to reset values immediately, without a clock edge.
  - after release the first entry is if_pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into a valid/ready fetch/decode slot.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_SIZE  = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cmd_address_current,
    input  logic [31:0] current_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    localparam int unsigned ADDR_W    = 32;
    localparam logic [ADDR_W-1:0] ROM_WORDS = ADDR_W'(ROM_SIZE);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              valid_q,    valid_d;
    logic [31:0]       instr_q,    instr_d;
    logic [ADDR_W-1:0] out_pc_q,   out_pc_d;
    logic              fault_q,    fault_d;

    logic fire;
    logic slot_free;
    logic load;
    logic bad;

    // State register; everything resets asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            out_pc_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state: redirect beats capture, capture beats plain consumption.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        fault_d  = fault_q;

        fire      = valid_q & if_ready;
        slot_free = ~valid_q | if_ready;
        load      = (state_q == RUN) & slot_free & ~redirect_valid;
        bad       = (pc_q[1:0] != 2'b00) | ({2'b00, pc_q[ADDR_W-1:2]} >= ROM_WORDS);

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = RUN;
        end else if (load && !bad) begin
            instr_d  = current_instruction;
            out_pc_d = pc_q;
            fault_d  = 1'b0;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
        end else if (load && bad) begin
            // Fault marker: PC stays on the offending address until redirected.
            instr_d  = NOP_INSTR;
            out_pc_d = pc_q;
            fault_d  = 1'b1;
            valid_d  = 1'b1;
            state_d  = FAULT;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    assign cmd_address_current = pc_q;
    assign if_valid            = valid_q;
    assign if_instr            = instr_q;
    assign if_pc               = out_pc_q;
    assign if_fault            = fault_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: transaction-level fetch model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_SIZE  = 8;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] ROM [8] = '{
        32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0030_0213,
        32'h0040_0293, 32'h0050_0313, 32'h0060_0393, 32'h0070_0413
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cmd_address_current;
    logic [31:0] current_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        if_ready       = 1'b1;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch #(
        .RESET_PC (RESET_PC),
        .ROM_SIZE (ROM_SIZE),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_address_current(cmd_address_current),
        .current_instruction(current_instruction),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .if_ready           (if_ready),
        .if_valid           (if_valid),
        .if_instr           (if_instr),
        .if_pc              (if_pc),
        .if_fault           (if_fault)
    );

    always #5 clk = ~clk;

    // Combinational ROM; out-of-range reads return garbage the DUT must never capture.
    assign current_instruction = (cmd_address_current < 32'(ROM_SIZE * 4))
                                 ? ROM[cmd_address_current[4:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch unit described as "next address, one slot, halt flag".
    logic [31:0] m_next_pc;
    bit          m_halted;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_fault;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_next_pc = RESET_PC;
            m_halted  = 0;
            m_valid   = 0;
            m_instr   = NOP_INSTR;
            m_pc      = 32'h0;
            m_fault   = 0;
        end else if (redirect_valid) begin
            m_next_pc = redirect_pc;
            m_halted  = 0;
            m_valid   = 0;
            m_fault   = 0;
        end else if (!m_halted && (!m_valid || if_ready)) begin
            m_valid = 1;
            m_pc    = m_next_pc;
            if ((m_next_pc % 4) != 0 || (m_next_pc / 4) >= ROM_SIZE) begin
                m_instr  = NOP_INSTR;
                m_fault  = 1;
                m_halted = 1;
            end else begin
                m_instr   = ROM[m_next_pc / 4];
                m_fault   = 0;
                m_next_pc = m_next_pc + 32'd4;
            end
        end else if (m_valid && if_ready) begin
            m_valid = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model.addr",  cmd_address_current, m_next_pc);
            chk("model.valid", 32'(if_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model.instr", if_instr, m_instr);
                chk("model.pc",    if_pc,    m_pc);
                chk("model.fault", 32'(if_fault), 32'(m_fault));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] pc,
                                input logic [31:0] instr, input logic fault);
        chk({tag, ".valid"}, 32'(if_valid), 32'd1);
        chk({tag, ".pc"},    if_pc,         pc);
        chk({tag, ".instr"}, if_instr,      instr);
        chk({tag, ".fault"}, 32'(if_fault), 32'(fault));
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        chk("redir.valid", 32'(if_valid), 32'd0);
        chk("redir.addr",  cmd_address_current, target);
    endtask

    task automatic expect_reset_values(input string tag);
        chk({tag, ".valid"}, 32'(if_valid), 32'd0);
        chk({tag, ".instr"}, if_instr,      NOP_INSTR);
        chk({tag, ".pc"},    if_pc,         32'h0);
        chk({tag, ".fault"}, 32'(if_fault), 32'd0);
        chk({tag, ".addr"},  cmd_address_current, RESET_PC);
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        expect_reset_values("rst");
        rst = 1'b0;

        // Sequential fetch straight out of reset.
        step(); expect_entry("seq0", 32'h0, 32'h0050_0093, 1'b0); chk("seq0.addr", cmd_address_current, 32'h4);
        step(); expect_entry("seq1", 32'h4, 32'h00A0_0113, 1'b0); chk("seq1.addr", cmd_address_current, 32'h8);
        step(); expect_entry("seq2", 32'h8, 32'h0020_81B3, 1'b0); chk("seq2.addr", cmd_address_current, 32'hC);

        // Backpressure holds the entry and the ROM address.
        redirect_to(32'h0);
        step(); expect_entry("bp.first", 32'h0, 32'h0050_0093, 1'b0);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_entry("bp.hold", 32'h0, 32'h0050_0093, 1'b0);
            chk("bp.addr", cmd_address_current, 32'h4);
        end
        if_ready = 1'b1;
        step(); expect_entry("bp.release", 32'h4, 32'h00A0_0113, 1'b0);

        // Redirect while the slot is stalled drops the entry.
        if_ready = 1'b0;
        redirect_to(32'h10);
        if_ready = 1'b1;
        step(); expect_entry("redir10", 32'h10, 32'h0040_0293, 1'b0);

        // Misaligned redirect: fault entry, then frozen until redirected.
        redirect_to(32'h6);
        step(); expect_entry("mis.fault", 32'h6, 32'h0000_0013, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mis.idle",  32'(if_valid), 32'd0);
            chk("mis.addr",  cmd_address_current, 32'h6);
        end
        redirect_to(32'h0);
        step(); expect_entry("mis.resume", 32'h0, 32'h0050_0093, 1'b0);

        // Run off the end of the ROM.
        redirect_to(32'h0);
        for (int i = 0; i < 8; i++) begin
            step(); expect_entry("oor.seq", 32'(i * 4), ROM[i], 1'b0);
        end
        step(); expect_entry("oor.fault", 32'h20, NOP_INSTR, 1'b1);
        chk("oor.addr", cmd_address_current, 32'h20);
        step(); step();
        chk("oor.frozen", cmd_address_current, 32'h20);
        chk("oor.idle",   32'(if_valid), 32'd0);

        // Asynchronous reset between edges.
        redirect_to(32'h0);
        step(); step(); step();
        chk("arst.pre", cmd_address_current, 32'hC);
        #2 rst = 1'b1;
        #1 expect_reset_values("arst");
        step();
        rst = 1'b0;
        step(); expect_entry("arst.first", RESET_PC, 32'h0050_0093, 1'b0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
